multicycle_controller: RTL

Moore-style control FSM for the multicycle RV32 datapath. It decodes op/funct fields and drives the shared ALU's 5-bit ALUControl, datapath muxes and write enables. It consumes the ALU's Zero flag to resolve branches. It sits between the instruction register and the single shared ALU/memory datapath.

---
 rtl/multicycle_controller.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32 datapath: decodes op/funct, sequences the
// shared ALU/memory datapath and resolves branches from the ALU Zero flag.
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [4:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01010;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_OR  = 5'b00111;
    localparam logic [4:0] ALU_SLT = 5'b00001;
    localparam logic [4:0] ALU_SLL = 5'b00000;
    localparam logic [4:0] ALU_SRL = 5'b10000;

    state_t state, next_state;
    logic   mem_store;

    logic is_lw, is_sw, is_r, is_i, is_br, is_jal;
    logic funct_ok, branch_ok, branch_taken, legal;
    logic [4:0] funct_alu, branch_alu;

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_i   = (op == OP_I);
    assign is_br  = (op == OP_BR);
    assign is_jal = (op == OP_JAL);

    // Shifts need funct7b5=0; arithmetic-right shifts are not supported.
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct3)
            3'b000: funct_alu = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: begin funct_alu = ALU_SLL; funct_ok = !funct7b5; end
            3'b010: funct_alu = ALU_SLT;
            3'b101: begin funct_alu = ALU_SRL; funct_ok = !funct7b5; end
            3'b110: funct_alu = ALU_OR;
            3'b111: funct_alu = ALU_AND;
            default: funct_ok = 1'b0;
        endcase
    end

    assign branch_ok    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
    assign branch_alu   = funct3[2] ? ALU_SLT : ALU_SUB;
    assign branch_taken = ((funct3 == 3'b000) || (funct3 == 3'b101)) ? Zero : !Zero;

    assign legal = ((is_lw || is_sw) && (funct3 == 3'b010)) ||
                   ((is_r || is_i) && funct_ok) ||
                   (is_br && branch_ok) ||
                   is_jal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            mem_store <= 1'b0;
        end else begin
            state <= next_state;
            // Load/store choice is latched so MEMADR does not depend on op later on.
            if (state == DECODE) mem_store <= is_sw;
        end
    end

    assign state_dbg = state;

    always_comb begin
        if (is_sw)                       ImmSrc = 2'b01;
        else if (is_br)                  ImmSrc = 2'b10;
        else if (is_jal)                 ImmSrc = 2'b11;
        else                             ImmSrc = 2'b00;
    end

    always_comb begin
        next_state    = state;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        RegWrite      = 1'b0;
        ALUControl    = 5'b00000;
        illegal_instr = 1'b0;
        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b01;
                ALUControl    = ALU_ADD;
                illegal_instr = !legal;
                if (!legal)                next_state = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                else if (is_lw || is_sw)   next_state = MEMADR;
                else if (is_r)             next_state = EXECUTER;
                else if (is_i)             next_state = EXECUTEI;
                else if (is_br)            next_state = BRANCH;
                else                       next_state = JAL;
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                next_state = mem_store ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                next_state = FETCH;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_alu;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_alu;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = branch_alu;
                PCWrite    = branch_taken;
                next_state = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            TRAP: begin
                illegal_instr = 1'b1;
                next_state    = TRAP;
            end
            default: next_state = FETCH;
        endcase
        // Write enables must be quiet while reset is held, whatever the state register says.
        if (reset) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule
